// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters through a round-robin arbiter,
// with a matched tag pipeline that routes each product back to its issuer.
module mult_arbiter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MULT_LATENCY = 3,
  parameter int unsigned NREQ         = 4,
  parameter int unsigned MAX_OUT      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    idle
);

  localparam int unsigned LAT  = MULT_LATENCY + 2;
  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW   = 2 * WIDTH;

  logic [IdW-1:0]             ptr_q, ptr_d;
  logic [NREQ-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0]             tag_vld_q;
  logic [LAT-1:0][IdW-1:0]    tag_id_q;

  logic [NREQ-1:0]            eligible;
  logic [NREQ-1:0]            grant;
  logic                       grant_any;
  logic [IdW-1:0]             win_id;

  logic [WIDTH-1:0]           dataa_q, dataa_d;
  logic [WIDTH-1:0]           datab_q, datab_d;
  logic [LAT-2:0][PW-1:0]     prod_q;

  // Response decode from the last tag stage
  always_comb begin
    rsp_valid = '0;
    if (tag_vld_q[LAT-1]) begin
      rsp_valid[tag_id_q[LAT-1]] = 1'b1;
    end
  end

  // A returning response frees its credit in the same cycle
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] & ((cnt_q[i] < CntW'(MAX_OUT)) | rsp_valid[i]);
    end
  end

  // Round-robin search beginning one past the last winner
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    win_id    = ptr_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        win_id    = IdW'(idx);
      end
    end
    if (grant_any) begin
      grant[win_id] = 1'b1;
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d = grant_any ? win_id : ptr_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      unique case ({grant[i], rsp_valid[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IdW'(NREQ - 1);
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= grant_any;
      tag_id_q[0]  <= win_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // Multiplier datapath: input register, MULT_LATENCY product stages, output register.
  // It carries no reset; in-flight products are dropped by the cleared tag valids.
  always_comb begin
    dataa_d = dataa_q;
    datab_d = datab_q;
    if (grant_any) begin
      dataa_d = req_a[32'(win_id)*WIDTH +: WIDTH];
      datab_d = req_b[32'(win_id)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    dataa_q   <= dataa_d;
    datab_q   <= datab_d;
    prod_q[0] <= PW'(dataa_q) * PW'(datab_q);
    for (int unsigned s = 1; s < LAT - 1; s++) begin
      prod_q[s] <= prod_q[s-1];
    end
  end

  assign rsp_data = prod_q[LAT-2];
  assign idle     = ~|tag_vld_q & ~|req_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized checks of mult_arbiter at WIDTH=8, MULT_LATENCY=3, NREQ=4, MAX_OUT=2.
module tb_mult_arbiter;

  localparam int LAT = 5;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        idle;

  int total;
  int bad;

  mult_arbiter #(
    .WIDTH(8),
    .MULT_LATENCY(3),
    .NREQ(4),
    .MAX_OUT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: ready=%b rsp=%b idle=%b want 0000 0000 1",
               req_ready, rsp_valid, idle);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 4'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: rsp=%b idle=%b want 0000 1", rsp_valid, idle);
    end
    step();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a = '0; req_b = '0;
    req_a[23:16] = 8'd7; req_b[23:16] = 8'd9;
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      req_valid = '0;
      @(negedge clk);
      total++;
      if (c == 5) begin
        if (rsp_valid !== 4'b0100 || rsp_data !== 16'd63) begin
          bad++; $display("FAIL single_rsp: got %b/%0d want 0100/63", rsp_valid, rsp_data);
        end
      end else if (rsp_valid !== 4'b0) begin
        bad++; $display("FAIL single_norsp c=%0d: got %b want 0000", c, rsp_valid);
      end
      if (c == 6) begin
        total++;
        if (idle !== 1'b1) begin
          bad++; $display("FAIL single_idle: got %b want 1", idle);
        end
      end
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [3:0] exp_rsp;
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'd10;
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      @(negedge clk);
      exp_rdy = 4'(1 << (c % 4));
      total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      if (c >= 5) begin
        exp_rsp = 4'(1 << ((c - 5) % 4));
        total++;
        if (rsp_valid !== exp_rsp || rsp_data !== 16'(((c - 5) % 4 + 1) * 10)) begin
          bad++;
          $display("FAIL rr_rsp c=%0d: got %b/%0d want %b/%0d", c, rsp_valid, rsp_data,
                   exp_rsp, ((c - 5) % 4 + 1) * 10);
        end
      end
    end
    step();
    drain();
  endtask

  task automatic test_credit_limit();
    logic [3:0] exp_rdy;
    logic [3:0] exp_rsp;
    do_reset();
    req_valid = 4'b0010; req_a = '0; req_b = '0;
    req_a[15:8] = 8'd3; req_b[15:8] = 8'd5;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      @(negedge clk);
      exp_rdy = ((c % 5) < 2) ? 4'b0010 : 4'b0000;
      exp_rsp = (c >= 5 && (c % 5) < 2) ? 4'b0010 : 4'b0000;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL credit_grant c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      total++;
      if (rsp_valid !== exp_rsp || (exp_rsp != 0 && rsp_data !== 16'd15)) begin
        bad++;
        $display("FAIL credit_rsp c=%0d: got %b/%0d want %b/15", c, rsp_valid, rsp_data, exp_rsp);
      end
    end
    step();
    drain();
  endtask

  task automatic test_boundary();
    logic [3:0]  exp_rsp;
    logic [15:0] exp_dat;
    req_a = '0; req_b = '0;
    req_a[7:0]   = 8'hFF; req_b[7:0]   = 8'hFF;
    req_a[15:8]  = 8'h00; req_b[15:8]  = 8'hFF;
    req_a[23:16] = 8'h01; req_b[23:16] = 8'h80;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      req_valid = (c < 3) ? 4'(1 << c) : 4'b0;
      @(negedge clk);
      if (c < 3) begin
        total++;
        if (req_ready !== 4'(1 << c)) begin
          bad++; $display("FAIL bnd_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << c));
        end
      end
      if (c >= 5) begin
        exp_rsp = 4'(1 << (c - 5));
        exp_dat = (c == 5) ? 16'hFE01 : (c == 6) ? 16'h0000 : 16'h0080;
        total++;
        if (rsp_valid !== exp_rsp || rsp_data !== exp_dat) begin
          bad++;
          $display("FAIL bnd_rsp c=%0d: got %b/%h want %b/%h", c, rsp_valid, rsp_data,
                   exp_rsp, exp_dat);
        end
      end
    end
    step();
    drain();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 2);
      req_b[i*8 +: 8] = 8'd3;
    end
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      if (c == 3) begin rst_n = 1'b0; req_valid = '0; end
      if (c == 4) rst_n = 1'b1;
      if (c == 10) begin req_valid = 4'b1000; req_a[31:24] = 8'd12; req_b[31:24] = 8'd11; end
      if (c == 11) req_valid = '0;
      @(negedge clk);
      if (c < 3) begin
        total++;
        if (req_ready !== 4'(1 << c)) begin
          bad++; $display("FAIL mid_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << c));
        end
      end
      if (c == 3) begin
        total++;
        if (idle !== 1'b1) begin
          bad++; $display("FAIL mid_idle: got %b want 1", idle);
        end
      end
      if (c == 10) begin
        total++;
        if (req_ready !== 4'b1000) begin
          bad++; $display("FAIL mid_regrant: got %b want 1000", req_ready);
        end
      end
      if (c >= 3 && c != 15) begin
        total++;
        if (rsp_valid !== 4'b0) begin
          bad++; $display("FAIL mid_norsp c=%0d: got %b want 0000", c, rsp_valid);
        end
      end
      if (c == 15) begin
        total++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 16'd132) begin
          bad++; $display("FAIL mid_rsp: got %b/%0d want 1000/132", rsp_valid, rsp_data);
        end
      end
    end
    step();
    drain();
  endtask

  task automatic test_mixed();
    int          m_ptr;
    int          m_cnt[4];
    bit          m_tv[LAT];
    int          m_tid[LAT];
    logic [15:0] m_tp[LAT];
    int          wait_cnt[4];
    bit          elig[4];
    bit          g_any;
    int          win;
    int          idx;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_rsp;
    do_reset();
    m_ptr = 3;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; wait_cnt[i] = 0; end
    for (int s = 0; s < LAT; s++) begin m_tv[s] = 0; m_tid[s] = 0; m_tp[s] = '0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = $urandom;
      req_b     = $urandom;
      @(negedge clk);
      exp_rsp = m_tv[LAT-1] ? 4'(1 << m_tid[LAT-1]) : 4'b0;
      for (int i = 0; i < 4; i++) begin
        elig[i] = req_valid[i] && (m_cnt[i] < 2 || exp_rsp[i]);
      end
      g_any = 0; win = 0;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!g_any && elig[idx]) begin g_any = 1; win = idx; end
      end
      exp_rdy = g_any ? 4'(1 << win) : 4'b0;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL mix_grant cyc=%0d: got %b want %b", cyc, req_ready, exp_rdy);
      end
      total++;
      if (rsp_valid !== exp_rsp || (exp_rsp != 0 && rsp_data !== m_tp[LAT-1])) begin
        bad++;
        $display("FAIL mix_rsp cyc=%0d: got %b/%h want %b/%h", cyc, rsp_valid, rsp_data,
                 exp_rsp, m_tp[LAT-1]);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dut.cnt_q[i] > 2) begin
          bad++; $display("FAIL mix_outcnt cyc=%0d req=%0d: got %0d want <=2", cyc, i,
                          dut.cnt_q[i]);
        end
        if (elig[i] && !(g_any && win == i)) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] >= 8) begin
          total++; bad++;
          $display("FAIL mix_fair cyc=%0d req=%0d: waited %0d want <8", cyc, i, wait_cnt[i]);
        end
        if (g_any && win == i) m_cnt[i]++;
        if (exp_rsp[i]) m_cnt[i]--;
      end
      for (int s = LAT - 1; s > 0; s--) begin
        m_tv[s] = m_tv[s-1]; m_tid[s] = m_tid[s-1]; m_tp[s] = m_tp[s-1];
      end
      m_tv[0]  = g_any;
      m_tid[0] = win;
      m_tp[0]  = 16'(req_a[win*8 +: 8]) * 16'(req_b[win*8 +: 8]);
      if (g_any) m_ptr = win;
      step();
    end
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_limit();
    test_boundary();
    test_reset_midflight();
    test_mixed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
